inv_key_sched: RTL and testbench

INV_KEY_SCHED -- requirements
Module: inv_key_sched

---
 rtl/inv_key_sched.sv | 167 ++++++++++++++++
 tb/tb_inv_key_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched.sv
// AES inverse key schedule: expands the key forward to the last Nk words, then walks
// the schedule backwards and emits round keys Nr..0 with a valid/ready handshake.
module inv_key_sched #(
  parameter int unsigned x = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:127+64*x] key,
  output logic [0:127]      rk,
  output logic [3:0]        rk_idx,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy,
  output logic              done
);
  localparam int unsigned NK = 4 + 2*x;
  localparam int unsigned NR = 10 + 2*x;
  localparam int unsigned T  = 44 + 8*x;

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q [NK];
  logic [31:0] w_d [NK];
  logic [5:0]  l_q, l_d;
  logic [3:0]  r_q, r_d;
  logic        done_q, done_d;

  logic [5:0]  ti, off;
  logic [31:0] tv, sw, temp, nw;
  logic        pend;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254 by an addition chain) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a14, a15, a30, a60, a120, a240, inv;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a14  = gmul(a12, a2);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    inv  = gmul(a240, a14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] j);
    case (j)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One SubWord shared by both directions: FWD feeds w[L+Nk-1], REV feeds w[L+Nk-2]
  always_comb begin
    ti   = (state_q == FWD) ? l_q + 6'(NK) : l_q + 6'(NK - 1);
    tv   = (state_q == FWD) ? w_q[NK-1] : w_q[NK-2];
    sw   = {sbox(tv[31:24]), sbox(tv[23:16]), sbox(tv[15:8]), sbox(tv[7:0])};
    temp = tv;
    if (ti % 6'(NK) == 6'd0)
      temp = {sw[23:0], sw[31:24]} ^ {rcon(ti / 6'(NK)), 24'h000000};
    else if (x == 2 && ti[2:0] == 3'd4)
      temp = sw;
    nw   = ((state_q == FWD) ? w_q[0] : w_q[NK-1]) ^ temp;
  end

  assign pend     = ({r_q, 2'b00} >= l_q);
  assign off      = {r_q, 2'b00} - l_q;
  assign rk_valid = (state_q == REV) && pend;
  assign rk_idx   = rk_valid ? r_q : 4'd0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    rk = '0;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned j = 0; j < NK; j++)
        if (rk_valid && j == 32'(off) + k) rk[32*k +: 32] = w_q[j];
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    l_d     = l_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          for (int unsigned j = 0; j < NK; j++) w_d[j] = key[32*j +: 32];
          l_d     = '0;
          r_d     = 4'(NR);
          state_d = FWD;
        end
      end
      FWD: begin
        for (int unsigned j = 0; j < NK - 1; j++) w_d[j] = w_q[j+1];
        w_d[NK-1] = nw;
        l_d       = l_q + 6'd1;
        if (ti == 6'(T - 1)) state_d = REV;
      end
      REV: begin
        // A pending round freezes the window; stepping only resumes once it is taken
        if (pend) begin
          if (rk_ready) begin
            if (r_q == 4'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              r_d = r_q - 4'd1;
            end
          end
        end else begin
          for (int unsigned j = 1; j < NK; j++) w_d[j] = w_q[j-1];
          w_d[0] = nw;
          l_d    = l_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int unsigned j = 0; j < NK; j++) w_q[j] <= '0;
      l_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      l_q     <= l_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched: one DUT per key size, FIPS-197 key vectors.
module tb_inv_key_sched;
  logic clk = 1'b0;
  logic rst, rk_ready;
  logic start0, start1, start2;
  logic [0:127] key0;
  logic [0:191] key1;
  logic [0:255] key2;
  logic [0:127] rk0, rk1, rk2;
  logic [3:0]   idx0, idx1, idx2;
  logic v0, v1, v2, b0, b1, b2, d0, d1, d2;

  int vectors = 0;
  int miscompares = 0;

  logic [0:127] s_rk;
  logic [3:0]   s_idx;
  logic         s_valid, s_busy, s_done;
  logic [0:127] got_rk [16];
  logic [3:0]   got_idx [16];
  int           got_edge [16];
  int           n_got, done_edge;

  logic [0:127] exp_a [11];
  logic [0:127] exp_z [11];
  logic [0:255] KA = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  logic [0:255] KZ = '0;
  logic [0:255] KB = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  logic [0:255] KC = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  inv_key_sched #(.x(0)) u_dut0 (.clk(clk), .rst(rst), .start(start0), .key(key0), .rk(rk0),
    .rk_idx(idx0), .rk_valid(v0), .rk_ready(rk_ready), .busy(b0), .done(d0));
  inv_key_sched #(.x(1)) u_dut1 (.clk(clk), .rst(rst), .start(start1), .key(key1), .rk(rk1),
    .rk_idx(idx1), .rk_valid(v1), .rk_ready(rk_ready), .busy(b1), .done(d1));
  inv_key_sched #(.x(2)) u_dut2 (.clk(clk), .rst(rst), .start(start2), .key(key2), .rk(rk2),
    .rk_idx(idx2), .rk_valid(v2), .rk_ready(rk_ready), .busy(b2), .done(d2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel);
    case (sel)
      0:       begin s_rk = rk0; s_idx = idx0; s_valid = v0; s_busy = b0; s_done = d0; end
      1:       begin s_rk = rk1; s_idx = idx1; s_valid = v1; s_busy = b1; s_done = d1; end
      default: begin s_rk = rk2; s_idx = idx2; s_valid = v2; s_busy = b2; s_done = d2; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic [0:255] k, input logic v);
    case (sel)
      0:       begin start0 = v; key0 = k[0:127]; end
      1:       begin start1 = v; key1 = k[0:191]; end
      default: begin start2 = v; key2 = k; end
    endcase
  endtask

  task automatic do_start(input int sel, input logic [0:255] k);
    set_start(sel, k, 1'b1);
    tick();
    set_start(sel, k, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Edges counted from the accepting edge; a valid sampled after edge e handshakes at e+1.
  task automatic collect(input int sel, input int inj_a, input int inj_b);
    n_got = 0;
    done_edge = -1;
    for (int e = 1; e <= 400; e++) begin
      if (e == inj_a || e == inj_b) set_start(sel, KZ, 1'b1);
      tick();
      if (e == inj_a || e == inj_b) set_start(sel, KZ, 1'b0);
      sample(sel);
      if (s_done) begin
        done_edge = e;
        break;
      end
      if (s_valid && n_got < 16) begin
        got_rk[n_got] = s_rk;
        got_idx[n_got] = s_idx;
        got_edge[n_got] = e + 1;
        n_got++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_start(0, KA, 1'b1);
    tick();
    set_start(0, KA, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      sample(s);
      vectors++;
      if ({s_valid, s_busy, s_done} !== 3'b000 || s_idx !== 4'd0 || s_rk !== 128'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got v/b/d=%b%b%b idx=%0d rk=%h, expected 000 0 0",
                 s, s_valid, s_busy, s_done, s_idx, s_rk);
      end
    end
  endtask

  task automatic check_aes128(input string name, input int first_exp);
    vectors++;
    if (n_got !== 11) begin
      miscompares++;
      $display("FAIL %s_count: got %0d rounds, expected 11", name, n_got);
    end
    for (int i = 0; i < 11 && i < n_got; i++) begin
      vectors++;
      if (got_idx[i] !== 4'(10 - i) || got_rk[i] !== ((first_exp == 0) ? exp_a[10-i] : exp_z[10-i])) begin
        miscompares++;
        $display("FAIL %s_round%0d: got idx %0d rk %h", name, 10 - i, got_idx[i], got_rk[i]);
      end
    end
    vectors++;
    if (got_edge[0] !== 41 || done_edge !== 91) begin
      miscompares++;
      $display("FAIL %s_timing: got first %0d done %0d, expected 41 91", name, got_edge[0], done_edge);
    end
  endtask

  task automatic test_aes128();
    pulse_rst();
    rk_ready = 1'b1;
    do_start(0, KA);
    collect(0, -1, -1);
    check_aes128("aes128", 0);
    for (int i = 1; i < n_got; i++) begin
      vectors++;
      if (got_edge[i] - got_edge[i-1] !== 5) begin
        miscompares++;
        $display("FAIL aes128_spacing%0d: got %0d, expected 5", i, got_edge[i] - got_edge[i-1]);
      end
    end
    vectors++;
    if (s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_at_done: got %b, expected 0", s_busy);
    end
    set_start(0, KZ, 1'b1);
    tick();
    set_start(0, KZ, 1'b0);
    sample(0);
    vectors++;
    if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_with_done: got done=%b busy=%b, expected 0 0", s_done, s_busy);
    end
    do_start(0, KZ);
    sample(0);
    vectors++;
    if (s_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_after_done: got busy=%b, expected 1", s_busy);
    end
  endtask

  task automatic test_stall();
    bit found;
    pulse_rst();
    rk_ready = 1'b1;
    do_start(0, KA);
    found = 0;
    for (int e = 0; e < 200; e++) begin
      tick();
      sample(0);
      if (s_valid && s_idx == 4'd7) begin
        rk_ready = 1'b0;
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL stall_reach7: got no round 7, expected round 7");
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      sample(0);
      vectors++;
      if (s_valid !== 1'b1 || s_idx !== 4'd7 || s_rk !== exp_a[7]) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%b idx=%0d rk=%h, expected 1 7 %h",
                 c, s_valid, s_idx, s_rk, exp_a[7]);
      end
    end
    rk_ready = 1'b1;
    tick();
    found = 0;
    for (int c = 0; c < 20; c++) begin
      sample(0);
      if (s_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    vectors++;
    if (!found || s_idx !== 4'd6 || s_rk !== exp_a[6]) begin
      miscompares++;
      $display("FAIL stall_release: got idx=%0d rk=%h, expected 6 %h", s_idx, s_rk, exp_a[6]);
    end
  endtask

  task automatic test_reset_mid_rev();
    bit found;
    pulse_rst();
    rk_ready = 1'b1;
    do_start(0, KA);
    found = 0;
    for (int e = 0; e < 200; e++) begin
      tick();
      sample(0);
      if (s_valid && s_idx == 4'd5) begin
        found = 1;
        break;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(0);
    vectors++;
    if (!found || {s_valid, s_busy, s_done} !== 3'b000 || s_idx !== 4'd0 || s_rk !== 128'h0) begin
      miscompares++;
      $display("FAIL midrev_reset: got v/b/d=%b%b%b idx=%0d rk=%h, expected 000 0 0",
               s_valid, s_busy, s_done, s_idx, s_rk);
    end
    do_start(0, KZ);
    collect(0, -1, -1);
    check_aes128("zerokey", 1);
  endtask

  task automatic test_back_to_back_start();
    pulse_rst();
    rk_ready = 1'b1;
    do_start(0, KA);
    collect(0, 20, 60);
    check_aes128("busy_start", 0);
  endtask

  task automatic test_aes192();
    pulse_rst();
    rk_ready = 1'b1;
    do_start(1, KB);
    collect(1, -1, -1);
    vectors++;
    if (n_got !== 13) begin
      miscompares++;
      $display("FAIL aes192_count: got %0d, expected 13", n_got);
    end
    for (int i = 0; i < 13 && i < n_got; i++) begin
      vectors++;
      if (got_idx[i] !== 4'(12 - i)) begin
        miscompares++;
        $display("FAIL aes192_order%0d: got %0d, expected %0d", i, got_idx[i], 12 - i);
      end
    end
    vectors++;
    if (got_rk[0] !== 128'he98ba06f448c773c8ecc720401002202) begin
      miscompares++;
      $display("FAIL aes192_r12: got %h, expected e98ba06f448c773c8ecc720401002202", got_rk[0]);
    end
    vectors++;
    if (got_rk[11] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5 || got_rk[12] !== KB[0:127]) begin
      miscompares++;
      $display("FAIL aes192_r1r0: got %h %h", got_rk[11], got_rk[12]);
    end
    vectors++;
    if (got_edge[0] !== 47 || done_edge !== 105) begin
      miscompares++;
      $display("FAIL aes192_timing: got first %0d done %0d, expected 47 105", got_edge[0], done_edge);
    end
  endtask

  task automatic test_aes256();
    pulse_rst();
    rk_ready = 1'b1;
    do_start(2, KC);
    collect(2, -1, -1);
    vectors++;
    if (n_got !== 15) begin
      miscompares++;
      $display("FAIL aes256_count: got %0d, expected 15", n_got);
    end
    for (int i = 0; i < 15 && i < n_got; i++) begin
      vectors++;
      if (got_idx[i] !== 4'(14 - i)) begin
        miscompares++;
        $display("FAIL aes256_order%0d: got %0d, expected %0d", i, got_idx[i], 14 - i);
      end
    end
    vectors++;
    if (got_rk[0] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      miscompares++;
      $display("FAIL aes256_r14: got %h, expected fe4890d1e6188d0b046df344706c631e", got_rk[0]);
    end
    vectors++;
    if (got_edge[1] - got_edge[0] !== 1) begin
      miscompares++;
      $display("FAIL aes256_r13_gap: got %0d, expected 1", got_edge[1] - got_edge[0]);
    end
    vectors++;
    if (got_rk[13] !== KC[128:255] || got_rk[14] !== KC[0:127]) begin
      miscompares++;
      $display("FAIL aes256_r1r0: got %h %h", got_rk[13], got_rk[14]);
    end
    vectors++;
    if (got_edge[0] !== 53 || done_edge !== 119) begin
      miscompares++;
      $display("FAIL aes256_timing: got first %0d done %0d, expected 53 119", got_edge[0], done_edge);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_z[0]  = 128'h00000000000000000000000000000000;
    exp_z[1]  = 128'h62636363626363636263636362636363;
    exp_z[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    exp_z[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    exp_z[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    exp_z[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    exp_z[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    exp_z[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    exp_z[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    exp_z[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    exp_z[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    rst = 1'b1;
    rk_ready = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    key0 = '0; key1 = '0; key2 = '0;
    test_reset();
    test_aes128();
    test_stall();
    test_reset_mid_rev();
    test_back_to_back_start();
    test_aes192();
    test_aes256();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
